// File: rtl/maxnet_pkg.sv
// Shared types, constants and fixed-point helpers for the MaxNet weight streamer.
package maxnet_pkg;

  // Streamer control states. The current state is visible on the top's dbg_state port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Legacy MaxNet configuration, used as the parameter defaults.
  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 5;
  localparam int DEF_FRAC  = 3;
  localparam int DEF_EPS   = 2;

  // Fixed-point 1.0 for the given number of fractional bits.
  function automatic int fx_one(input int frac);
    return 1 << frac;
  endfunction

  // Two's-complement negation of val, truncated to width bits.
  function automatic int fx_neg(input int val, input int width);
    return (~val + 1) & ((1 << width) - 1);
  endfunction

endpackage

// File: rtl/maxnet_weight_streamer_if.sv
// Row stream bus from the weight streamer to the MaxNet MAC array.
//
// Handshake: a row transfers on every rising edge where row_valid and
// row_ready are both high. Once row_valid is raised, row_data, row_idx and
// row_last stay stable until that transfer happens. row_valid never depends
// combinationally on row_ready.
interface maxnet_weight_streamer_if #(
  parameter int N     = 4,
  parameter int WIDTH = 5
) ();
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic                 row_valid;
  logic                 row_ready;
  logic [N*WIDTH-1:0]   row_data;
  logic [IW-1:0]        row_idx;
  logic                 row_last;

  modport master (
    output row_valid,
    output row_data,
    output row_idx,
    output row_last,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_data,
    input  row_idx,
    input  row_last,
    output row_ready
  );
endinterface

// File: rtl/maxnet_row_gen.sv
// Combinational generator for one row of the MaxNet weight matrix:
// ONE on the diagonal, zero (identity mode) or -eps off the diagonal.
module maxnet_row_gen
  import maxnet_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IW-1:0]      row_idx,
  input  logic [WIDTH-2:0]   eps,
  input  logic               mode,
  output logic [N*WIDTH-1:0] row
);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(fx_one(FRAC));

  logic [WIDTH-1:0] off_val;

  // Off-diagonal value shared by every non-diagonal element of the row.
  always_comb begin
    off_val = '0;
    if (!mode) off_val = WIDTH'(fx_neg(int'(eps), WIDTH));
  end

  // Place ONE at column row_idx and the off-diagonal value elsewhere.
  always_comb begin
    row = '0;
    for (int j = 0; j < N; j++) begin
      if (j == int'(row_idx)) row[j*WIDTH +: WIDTH] = ONE_W;
      else                    row[j*WIDTH +: WIDTH] = off_val;
    end
  end
endmodule

// File: rtl/maxnet_weight_streamer.sv
// Streams an N x N MaxNet weight matrix row by row over a valid/ready bus.
// Epsilon and identity mode are captured on start and held for the whole matrix.
module maxnet_weight_streamer
  import maxnet_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FRAC        = DEF_FRAC,
  parameter int DEFAULT_EPS = DEF_EPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-2:0] eps_in,
  input  logic             use_default,
  input  logic             mode_identity,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state,
  maxnet_weight_streamer_if.master rowif
);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int ONE_I = fx_one(FRAC);

  // Elaboration-time parameter sanity.
  if (FRAC > WIDTH - 2) begin : g_bad_frac
    $error("maxnet_weight_streamer: FRAC must be <= WIDTH-2 so ONE is positive");
  end
  if (N < 2) begin : g_bad_n
    $error("maxnet_weight_streamer: N must be >= 2");
  end

  state_e             state_q, state_n;
  logic [IW-1:0]      idx_q, idx_n;
  logic [WIDTH-2:0]   eps_q, eps_n, eps_eff;
  logic               mode_q, mode_n;
  logic               valid_q, valid_n;
  logic               done_q, done_n;
  logic [N*WIDTH-1:0] data_q, gen_row;
  int                 eps_sel;

  // Effective epsilon: default substitution for zero, then clamp to ONE.
  always_comb begin
    eps_sel = int'(eps_in);
    if (eps_in == '0 && use_default) eps_sel = DEFAULT_EPS;
    if (eps_sel > ONE_I) eps_sel = ONE_I;
    eps_eff = (WIDTH-1)'(eps_sel);
  end

  // Next-state logic; start and the config inputs matter only in IDLE.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    eps_n   = eps_q;
    mode_n  = mode_q;
    valid_n = valid_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        valid_n = 1'b0;
        if (start) begin
          state_n = STREAM;
          idx_n   = '0;
          eps_n   = eps_eff;
          mode_n  = mode_identity;
          valid_n = 1'b1;
        end
      end
      STREAM: begin
        valid_n = 1'b1;
        if (rowif.row_ready) begin
          if (idx_q == IW'(N - 1)) begin
            state_n = DONE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  // Row generator fed with next-cycle values so row_data lands in step with row_idx.
  maxnet_row_gen #(
    .N     (N),
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_row_gen (
    .row_idx (idx_n),
    .eps     (eps_n),
    .mode    (mode_n),
    .row     (gen_row)
  );

  // State, latched configuration and registered row outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      eps_q   <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      eps_q   <= eps_n;
      mode_q  <= mode_n;
      valid_q <= valid_n;
      done_q  <= done_n;
      data_q  <= valid_n ? gen_row : '0;
    end
  end

  assign rowif.row_valid = valid_q;
  assign rowif.row_data  = data_q;
  assign rowif.row_idx   = idx_q;
  assign rowif.row_last  = valid_q && (idx_q == IW'(N - 1));
  assign busy            = (state_q == STREAM);
  assign done            = done_q;
  assign dbg_state       = state_q;
endmodule

// File: doc/maxnet_weight_streamer.md
Name: maxnet_weight_streamer

Overview:
- Parametrised successor to the fixed 4x4 MaxNet weight buffer.
- Generates an N x N MaxNet weight matrix: ONE on the diagonal, -epsilon off the diagonal.
- Epsilon is runtime-programmable; an identity mode is provided.
- Streams the matrix row by row over a valid/ready handshake into the MaxNet MAC array, replacing the initial-block constant buffer.

Parameters:
- N, 4, matrix dimension (neuron count), N >= 2
- WIDTH, 5, signed two's-complement weight width
- FRAC, 3, fractional bits; ONE = 1 << FRAC (01000 at defaults)
- DEFAULT_EPS, 2, epsilon magnitude in LSBs used when eps_in == 0 and use_default == 1

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to stream one matrix
- eps_in  input  WIDTH-1  unsigned epsilon magnitude in LSBs
- use_default  input  1  1: use DEFAULT_EPS when eps_in == 0
- mode_identity  input  1  1: off-diagonal = 0 (identity matrix)
- row_valid  output  1  row_data is valid
- row_ready  input  1  consumer accepts the row
- row_data  output  N*WIDTH  current row; element j at bits [j*WIDTH +: WIDTH]
- row_idx  output  clog2(N)  index of the current row
- row_last  output  1  high with row N-1
- busy  output  1  high in STREAM
- done  output  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, row_valid=0, row_data=0, row_idx=0, row_last=0, busy=0, done=0, latched eps=0, latched mode=0.
- Asserting rst mid-stream aborts the stream. No done pulse is produced.
- States: IDLE, STREAM, DONE.
- IDLE -> STREAM when start=1.
  - On that edge, latch eps_eff, mode_identity and row_idx=0.
  - row_valid rises on the following cycle (1-cycle latency from start).
- STREAM:
  - row_valid=1 and busy=1.
  - A handshake is valid & ready on a rising edge.
  - On a handshake with row_idx < N-1: row_idx increments.
  - On a handshake with row_idx == N-1: go to DONE and drop row_valid.
  - row_valid & !row_ready stalls: row_data, row_idx and row_last hold stable indefinitely.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored while in STREAM or DONE. No queuing.
- Inputs eps_in, use_default and mode_identity are sampled only on the start edge. Changes mid-stream have no effect.
- eps_eff:
  - Equals eps_in.
  - If eps_in == 0 and use_default == 1, eps_eff = DEFAULT_EPS.
  - eps_eff is then clamped to ONE.
  - eps_eff == 0 with use_default == 0 yields zero off-diagonals.
- Element (r, j):
  - j == r: ONE
  - j != r and mode_identity = 1: 0
  - otherwise: (~eps_eff + 1) truncated to WIDTH bits
- Defaults check: eps=2 gives 11110 and ONE gives 01000. This matches the legacy matrix.
- row_data and row_idx are registered outputs, not combinational from the handshake inputs.
- row_last = (row_idx == N-1) & row_valid.
- Elaboration checks:
  - FRAC <= WIDTH-2, so ONE is representable as a positive value.
  - N >= 2.

Decomposition:
- Package maxnet_pkg holds:
  - state enum {IDLE, STREAM, DONE}
  - function fx_one(FRAC)
  - function fx_neg(val, WIDTH)
  - shared fixed-point constants
- One sub-module, maxnet_row_gen: purely combinational.
  - Inputs: row_idx, eps_eff, mode.
  - Output: the N*WIDTH row vector.
  - The top-level registers this output.

Test Plan:
1. Defaults (N=4, WIDTH=5, FRAC=3), start with eps_in=2 and row_ready=1 held → four consecutive rows.
   - Row 0 = {11110,11110,11110,01000}, element 0 in the LSBs.
   - row_last is high on row 3 only.
   - done pulses one cycle after row 3 is accepted.
2. Backpressure: row_ready=0 for 5 cycles during row 1 → row_data and row_idx=1 stay stable, with no skipped or duplicated rows.
3. mode_identity=1, eps_in=3 → diagonals 01000, all off-diagonals 00000.
4. Epsilon handling:
   - eps_in=0, use_default=1 → off-diagonals 11110.
   - eps_in=15 → clamped to 8, off-diagonals 11000.
5. start pulsed during STREAM, and eps_in changed mid-stream → ignored; the stream completes with the original values.
6. rst asserted on row 2 mid-handshake:
   - Outputs are zero immediately and no done pulse occurs.
   - A new start afterwards streams from row 0.
